steg_decode: RTL and testbench



---
 rtl/steg_pkg.sv | 8 +
 rtl/steg_pix_addr.sv | 18 +
 rtl/steg_decode.sv | 76 +++++++
 tb/tb_steg_decode.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/steg_pkg.sv
// steg_pkg: image/message geometry and decoder state encoding shared by the steganography encoder and decoder.
package steg_pkg;
  localparam int IMG_DIM = 64;
  localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;
  localparam int MSG_BYTES = IMG_PIXELS / 8;
  localparam int BIT_POS_DEF = 8;
  typedef enum logic [1:0] {IDLE, READ, EMIT, DONE} dec_state_t;
endpackage

// File: rtl/steg_pix_addr.sv
// steg_pix_addr: row-major row/col scan counter with clear, enable and a last-pixel flag.
module steg_pix_addr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         last_pixel
);
  assign last_pixel = &{row, col};
  // col is the low half, so the carry out of col advances row and 63/63 wraps to 0/0
  always_ff @(posedge clk)
    if (rst || clr) {row, col} <= '0;
    else if (en) {row, col} <= {row, col} + 1'b1;
endmodule

// File: rtl/steg_decode.sv
// steg_decode: scans the encoded image, extracts one hidden bit per pixel and streams bytes MSB-first.
// Build option STEG_DEC_NUL_STOP_EN: stop at the first accepted 0x00 byte.
module steg_decode
  import steg_pkg::*;
#(
  parameter int DIM_LOG2 = $clog2(IMG_DIM),
  parameter int BIT_POS = BIT_POS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [23:0]                 in_pix,
  output logic [DIM_LOG2-1:0]         row,
  output logic [DIM_LOG2-1:0]         col,
  output logic [7:0]                  out_byte,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic [$clog2(MSG_BYTES):0]  byte_count,
  output logic                        decode_done
);
  dec_state_t state, state_nx;
  logic [7:0] sreg;
  logic [2:0] bit_cnt;
  logic final_byte, last_pixel, addr_clr, nul_stop;
  assign addr_clr = (state == IDLE || state == DONE) && start;
`ifdef STEG_DEC_NUL_STOP_EN
  assign nul_stop = sreg == 8'h00;
`else
  assign nul_stop = 1'b0;
`endif
  steg_pix_addr #(.W(DIM_LOG2)) u_addr (
    .clk(clk),
    .rst(rst),
    .clr(addr_clr),
    .en(state == READ),
    .row(row),
    .col(col),
    .last_pixel(last_pixel)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? READ : state;
      READ:       state_nx = bit_cnt == 3'd7 ? EMIT : READ;
      EMIT:       state_nx = !out_ready ? EMIT : (final_byte || nul_stop) ? DONE : READ;
      default:    state_nx = IDLE;
    endcase
  end
  // final_byte marks the byte whose last bit came from the bottom-right pixel
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sreg <= '0;
      bit_cnt <= '0;
      byte_count <= '0;
      final_byte <= 1'b0;
    end else begin
      state <= state_nx;
      if (addr_clr) begin
        bit_cnt <= '0;
        byte_count <= '0;
        final_byte <= 1'b0;
      end
      if (state == READ) begin
        sreg <= {sreg[6:0], in_pix[BIT_POS]};
        bit_cnt <= bit_cnt + 1'b1;
        if (last_pixel) final_byte <= 1'b1;
      end
      if (state == EMIT && out_ready) byte_count <= byte_count + 1'b1;
    end
  assign out_byte = sreg;
  assign out_valid = state == EMIT;
  assign busy = state == READ || state == EMIT;
  assign decode_done = state == DONE;
endmodule

// File: tb/tb_steg_decode.sv
// tb_steg_decode: directed self-checking bench for steg_decode against an image built from a known message.
module tb_steg_decode;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [23:0] in_pix;
  logic [5:0] row, col;
  logic [7:0] out_byte;
  logic out_valid, busy, decode_done;
  logic [9:0] byte_count;
  logic [23:0] mem [4096];
  logic [7:0] msg [512];
  int checks = 0, errors = 0, cyc = 0, c0 = 0;

  always #5 clk = ~clk;
  assign in_pix = mem[{row, col}];

  steg_decode dut (
    .clk(clk), .rst(rst), .start(start), .in_pix(in_pix), .row(row), .col(col),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .byte_count(byte_count), .decode_done(decode_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // hidden bit goes to in_pix[8]; every other bit is its complement so a wrong tap shows up
  task automatic load_img(input bit white);
    logic [7:0] b;
    for (int k = 0; k < 4096; k++) begin
      b = msg[k / 8];
      mem[k] = white ? 24'hFFFFFF : b[7 - (k % 8)] ? 24'h0A01F0 : 24'hF5FE0F;
    end
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " row"}, 32'(row), 0);
    chk({tag, " col"}, 32'(col), 0);
    chk({tag, " byte"}, 32'(out_byte), 0);
    chk({tag, " valid"}, 32'(out_valid), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " count"}, 32'(byte_count), 0);
    chk({tag, " done"}, 32'(decode_done), 0);
  endtask

  task automatic recv(input logic [7:0] exp, input int stall, input int idx);
    int n;
    logic [5:0] r, c;
    string tag;
    tag = $sformatf("b%0d", idx);
    n = 0;
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk({tag, " valid"}, 32'(out_valid), 1);
    r = row;
    c = col;
    for (int i = 0; i < stall; i++) begin
      tick;
      chk({tag, " stall valid"}, 32'(out_valid), 1);
      chk({tag, " stall byte"}, 32'(out_byte), 32'(exp));
      chk({tag, " stall row"}, 32'(row), 32'(r));
      chk({tag, " stall col"}, 32'(col), 32'(c));
      chk({tag, " stall count"}, 32'(byte_count), idx);
    end
    chk({tag, " byte"}, 32'(out_byte), 32'(exp));
    chk({tag, " pre count"}, 32'(byte_count), idx);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, " count"}, 32'(byte_count), idx + 1);
    chk({tag, " vclr"}, 32'(out_valid), 0);
  endtask

  task automatic full(input bit white);
    for (int j = 0; j < 512; j++) recv(white ? 8'hFF : msg[j], 0, j);
    chk("end done", 32'(decode_done), 1);
    chk("end busy", 32'(busy), 0);
    chk("end count", 32'(byte_count), 512);
    chk("end row", 32'(row), 0);
    chk("end col", 32'(col), 0);
    chk("end cycles", cyc - c0, 4609);
  endtask

  initial begin
    for (int j = 0; j < 512; j++) msg[j] = 8'(j * 37 + 11);
    msg[0] = 8'h41;
    msg[1] = 8'h69;
    msg[5] = 8'h00;
    load_img(1'b0);
    tick;
    tick;
    chk_idle("reset");
    rst = 1'b0;
`ifdef STEG_DEC_NUL_STOP_EN
    msg[0] = 8'h48;
    msg[1] = 8'h69;
    msg[2] = 8'h00;
    load_img(1'b0);
    do_start;
    recv(8'h48, 0, 0);
    recv(8'h69, 0, 1);
    recv(8'h00, 0, 2);
    chk("nul done", 32'(decode_done), 1);
    chk("nul busy", 32'(busy), 0);
    chk("nul count", 32'(byte_count), 3);
    chk("nul row", 32'(row), 0);
    chk("nul col", 32'(col), 24);
    repeat (10) tick;
    chk("nul hold done", 32'(decode_done), 1);
    chk("nul hold valid", 32'(out_valid), 0);
`else
    out_ready = 1'b1;
    do_start;
    chk("go busy", 32'(busy), 1);
    chk("go row", 32'(row), 0);
    chk("go col", 32'(col), 0);
    chk("go done", 32'(decode_done), 0);
    repeat (7) tick;
    chk("lat8 valid", 32'(out_valid), 0);
    chk("lat8 col", 32'(col), 7);
    tick;
    chk("lat9 valid", 32'(out_valid), 1);
    chk("lat9 byte", 32'(out_byte), 32'h41);
    chk("lat9 row", 32'(row), 0);
    chk("lat9 col", 32'(col), 8);
    recv(8'h41, 0, 0);
    recv(8'h69, 0, 1);
    recv(msg[2], 5, 2);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy start busy", 32'(busy), 1);
    chk("busy start row", 32'(row), 0);
    chk("busy start col", 32'(col), 25);
    recv(msg[3], 0, 3);
    for (int j = 4; j < 100; j++) recv(msg[j], 0, j);
    repeat (4) tick;
    chk("mid busy", 32'(busy), 1);
    chk("mid count", 32'(byte_count), 100);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_idle("midrst");
    tick;
    chk_idle("idle");
    c0 = cyc;
    do_start;
    chk("replay row", 32'(row), 0);
    chk("replay col", 32'(col), 0);
    full(1'b0);
    c0 = cyc;
    do_start;
    chk("restart done", 32'(decode_done), 0);
    chk("restart busy", 32'(busy), 1);
    chk("restart count", 32'(byte_count), 0);
    full(1'b0);
    load_img(1'b1);
    c0 = cyc;
    do_start;
    full(1'b1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
